// File: rtl/io_arbiter.sv
// Two-requester arbiter for the processor's single I/O port: latches one request, drives the
// level strobes until the I/O module's ready pulse, acks the requester, then holds a quiet gap.
module io_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
  parameter int unsigned GAP_CYCLES     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [9:0]  req0_adress,
  input  logic [31:0] req0_data,
  input  logic [31:0] req0_drs,
  output logic        req0_ack,
  output logic        req0_err,
  output logic [31:0] req0_rdata,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [9:0]  req1_adress,
  input  logic [31:0] req1_data,
  input  logic [31:0] req1_drs,
  output logic        req1_ack,
  output logic        req1_err,
  output logic [31:0] req1_rdata,
  output logic [31:0] io_p_data,
  output logic [31:0] io_drs,
  output logic [9:0]  io_adress,
  output logic        io_in_req,
  output logic        io_new_out,
  input  logic        io_in_ready,
  input  logic        io_out_ready,
  input  logic [31:0] io_e_data,
  output logic        grant,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StBusy, StGap} state_e;

  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 16'd1);
  localparam logic [7:0]  GapLast = 8'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  gap_q, gap_d;
  logic [31:0] p_data_q, p_data_d, drs_q, drs_d;
  logic [9:0]  adr_q, adr_d;
  logic        in_req_q, in_req_d, new_out_q, new_out_d;
  logic        grant_q, grant_d;
  logic [1:0]  ack_q, ack_d, err_q, err_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic        sel;
  logic        sel_write;
  logic [9:0]  sel_adr;
  logic        adr_legal;
  logic        done;

  always_comb begin
    sel       = req1_valid & (~req0_valid | ptr_q);
    sel_write = sel ? req1_write : req0_write;
    sel_adr   = sel ? req1_adress : req0_adress;
    adr_legal = (sel_adr == 10'd0) || (sel_adr == 10'd32) || (sel_adr == 10'd64) ||
                (sel_adr == 10'd96) || (sel_adr == 10'd128);
    // Only the ready pulse matching the active strobe counts as completion.
    done      = (new_out_q & io_out_ready) | (in_req_q & io_in_ready);
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    tmo_d     = tmo_q;
    gap_d     = gap_q;
    p_data_d  = p_data_q;
    drs_d     = drs_q;
    adr_d     = adr_q;
    in_req_d  = in_req_q;
    new_out_d = new_out_q;
    grant_d   = grant_q;
    ack_d     = 2'b00;
    err_d     = 2'b00;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    unique case (state_q)
      StIdle: begin
        if (req0_valid || req1_valid) begin
          grant_d  = sel;
          p_data_d = sel ? req1_data : req0_data;
          drs_d    = sel ? req1_drs : req0_drs;
          adr_d    = sel_adr;
          if (adr_legal) begin
            new_out_d = sel_write;
            in_req_d  = ~sel_write;
            tmo_d     = '0;
            state_d   = StBusy;
          end else begin
            ack_d[sel] = 1'b1;
            err_d[sel] = 1'b1;
            gap_d      = '0;
            state_d    = StGap;
          end
        end
      end
      StBusy: begin
        if (done || tmo_q == TmoLast) begin
          new_out_d      = 1'b0;
          in_req_d       = 1'b0;
          ack_d[grant_q] = 1'b1;
          err_d[grant_q] = ~done;
          if (done && in_req_q) begin
            if (grant_q) rdata1_d = io_e_data;
            else         rdata0_d = io_e_data;
          end
          ptr_d   = ~ptr_q;
          tmo_d   = '0;
          gap_d   = '0;
          state_d = StGap;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      StGap: begin
        if (gap_q == GapLast) state_d = StIdle;
        else                  gap_d   = gap_q + 8'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      ptr_q     <= 1'b0;
      tmo_q     <= '0;
      gap_q     <= '0;
      p_data_q  <= '0;
      drs_q     <= '0;
      adr_q     <= '0;
      in_req_q  <= 1'b0;
      new_out_q <= 1'b0;
      grant_q   <= 1'b0;
      ack_q     <= 2'b00;
      err_q     <= 2'b00;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      tmo_q     <= tmo_d;
      gap_q     <= gap_d;
      p_data_q  <= p_data_d;
      drs_q     <= drs_d;
      adr_q     <= adr_d;
      in_req_q  <= in_req_d;
      new_out_q <= new_out_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign req0_ack   = ack_q[0];
  assign req1_ack   = ack_q[1];
  assign req0_err   = err_q[0];
  assign req1_err   = err_q[1];
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;
  assign io_p_data  = p_data_q;
  assign io_drs     = drs_q;
  assign io_adress  = adr_q;
  assign io_in_req  = in_req_q;
  assign io_new_out = new_out_q;
  assign grant      = grant_q;
  assign busy       = (state_q != StIdle);

endmodule
